// File: rtl/tree_input_packer_pkg.sv
// Shared MTTKRP types and sizing helpers for the adder-tree packers.
package tree_input_packer_pkg;

  localparam int NUM_TOT_ELEMENT    = 8;
  localparam int RANK_FACTOR_MATRIX = 16;
  localparam int N                  = 32;

  // One partial-product vector at the default sizing.
  typedef logic [RANK_FACTOR_MATRIX-1:0][N-1:0] vec_t;

  // Packer state: EMPTY has no buffered element, FILL holds at least one.
  typedef enum logic {ST_EMPTY, ST_FILL} pack_state_e;

  // Ceiling log2, replaces per-module log2 functions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Count fields must hold the value NUM itself, hence the extra bit.
  function automatic int cnt_w(input int num);
    return clog2(num) + 1;
  endfunction

  localparam int CNT_W = cnt_w(NUM_TOT_ELEMENT);

endpackage

// File: rtl/tree_input_packer_slot_mask_gen.sv
// Fill counter to one-hot slot write enable; reusable by other packers.
module slot_mask_gen #(
  parameter int NUM   = 8,
  parameter int CNT_W = 4
) (
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic [NUM-1:0]   mask
);

  for (genvar k = 0; k < NUM; k++) begin : g_slot
    // Slot k is written only when an element is accepted at fill position k.
    assign mask[k] = en && (cnt == CNT_W'(k));
  end

endmodule

// File: rtl/tree_input_packer.sv
// Gathers one partial-product vector per cycle into NUM_TOT_ELEMENT-slot
// batches and issues each batch as a one-cycle wide word to the adder tree.
module tree_input_packer
  import tree_input_packer_pkg::*;
#(
  parameter  int NUM_TOT_ELEMENT    = 8,
  parameter  int RANK_FACTOR_MATRIX = 16,
  parameter  int N                  = 32,
  localparam int CNT_W              = cnt_w(NUM_TOT_ELEMENT)
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    in_avl,
  input  logic                                                    in_last,
  input  logic                                                    flush,
  input  logic [RANK_FACTOR_MATRIX-1:0][N-1:0]                    in_data,
  output logic                                                    out_avl,
  output logic [NUM_TOT_ELEMENT-1:0][RANK_FACTOR_MATRIX-1:0][N-1:0] out_data,
  output logic [CNT_W-1:0]                                        out_count,
  output logic                                                    out_last
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_TOT_ELEMENT - 1);

  pack_state_e state_q, state_d;

  logic [CNT_W-1:0]                                        cnt_q;
  logic [NUM_TOT_ELEMENT-1:0]                              slot_vld;
  logic [NUM_TOT_ELEMENT-1:0][RANK_FACTOR_MATRIX-1:0][N-1:0] slot_buf;
  logic [NUM_TOT_ELEMENT-1:0][RANK_FACTOR_MATRIX-1:0][N-1:0] merged;
  logic [NUM_TOT_ELEMENT-1:0]                              wr_en;
  logic full_close, short_close, close;

  slot_mask_gen #(
    .NUM  (NUM_TOT_ELEMENT),
    .CNT_W(CNT_W)
  ) u_slot_mask_gen (
    .en  (in_avl),
    .cnt (cnt_q),
    .mask(wr_en)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Close decode and next state; the incoming element always joins the batch.
  always_comb begin
    full_close  = in_avl && (cnt_q == LAST_SLOT);
    short_close = in_avl ? (in_last || flush) : (flush && (state_q == ST_FILL));
    close       = full_close || short_close;
    state_d     = state_q;
    if (close)       state_d = ST_EMPTY;
    else if (in_avl) state_d = ST_FILL;
  end

  // Batch image as it would be issued this cycle: buffered slots plus the
  // incoming element, with never-written slots forced to zero.
  always_comb begin
    merged = '0;
    for (int k = 0; k < NUM_TOT_ELEMENT; k++) begin
      if (wr_en[k])         merged[k] = in_data;
      else if (slot_vld[k]) merged[k] = slot_buf[k];
    end
  end

  // Fill buffer, slot mask and counter; everything clears on close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      slot_vld <= '0;
      slot_buf <= '0;
    end else if (close) begin
      cnt_q    <= '0;
      slot_vld <= '0;
      slot_buf <= '0;
    end else if (in_avl) begin
      cnt_q <= cnt_q + CNT_W'(1);
      for (int k = 0; k < NUM_TOT_ELEMENT; k++) begin
        if (wr_en[k]) begin
          slot_buf[k] <= in_data;
          slot_vld[k] <= 1'b1;
        end
      end
    end
  end

  // Output register set: one-cycle strobe, payload held until the next close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_avl   <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      out_avl <= close;
      if (close) begin
        out_data  <= merged;
        out_count <= cnt_q + {{(CNT_W-1){1'b0}}, in_avl};
        out_last  <= short_close;
      end
    end
  end

endmodule

// File: tb/tb_tree_input_packer.sv
// Directed plus randomized bench for tree_input_packer (NUM=8, RANK=2, N=32).
module tb_tree_input_packer;

  localparam int NUM  = 8;
  localparam int RANK = 2;
  localparam int NB   = 32;
  localparam int CW   = 4;

  typedef logic [RANK-1:0][NB-1:0] v_t;
  typedef logic [NUM-1:0][RANK-1:0][NB-1:0] b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_avl = 1'b0, in_last = 1'b0, flush = 1'b0;
  v_t   in_data = '0;
  logic out_avl, out_last;
  b_t   out_data;
  logic [CW-1:0] out_count;

  int n_chk = 0, n_pass = 0, pulses = 0;

  tree_input_packer #(
    .NUM_TOT_ELEMENT   (NUM),
    .RANK_FACTOR_MATRIX(RANK),
    .N                 (NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_avl   (in_avl),
    .in_last  (in_last),
    .flush    (flush),
    .in_data  (in_data),
    .out_avl  (out_avl),
    .out_data (out_data),
    .out_count(out_count),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: a queue of accepted vectors, emptied into an expected
  // batch whenever the stream rules say the batch ends.
  v_t   q[$];
  logic exp_avl = 1'b0, exp_last = 1'b0;
  b_t   exp_data = '0;
  int   exp_count = 0;
  bit   m_close, m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_avl = 1'b0; exp_data = '0; exp_count = 0; exp_last = 1'b0;
    end else begin
      exp_avl = 1'b0; m_close = 0; m_last = 0;
      if (in_avl) begin
        q.push_back(in_data);
        if (q.size() == NUM) m_close = 1;
        if (in_last || flush) begin m_close = 1; m_last = 1; end
      end else if (flush && q.size() > 0) begin
        m_close = 1; m_last = 1;
      end
      if (m_close) begin
        exp_data = '0;
        foreach (q[k]) exp_data[k] = q[k];
        exp_count = q.size();
        exp_last  = m_last;
        exp_avl   = 1'b1;
        q.delete();
      end
    end
  end

  // Compare every cycle out of reset; payload only when a batch is due.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_avl === 1'b1) pulses++;
      chk("out_avl", 512'(out_avl), 512'(exp_avl));
      if (exp_avl) begin
        chk("out_data", 512'(out_data), 512'(exp_data));
        chk("out_count", 512'(out_count), 512'(exp_count));
        chk("out_last", 512'(out_last), 512'(exp_last));
      end
    end
  end

  // Present one cycle of input, then settle 1 time unit past the edge.
  task automatic drive(input logic a, input logic l, input logic f, input v_t d);
    in_avl = a; in_last = l; flush = f; in_data = d;
    @(posedge clk); #1;
    in_avl = 1'b0; in_last = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_avl = 1'b0; in_last = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    v_t d;
    b_t eb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_avl", 512'(out_avl), 512'(0));
    chk("reset_data", 512'(out_data), 512'(0));
    chk("reset_count", 512'(out_count), 512'(0));
    chk("reset_last", 512'(out_last), 512'(0));
    rst = 1'b0;

    // 16 back-to-back elements {i, 100+i}: pulses after the 8th and 16th.
    for (int i = 0; i < 16; i++) begin
      d[1] = 32'(i); d[0] = 32'(100 + i);
      drive(1'b1, 1'b0, 1'b0, d);
      if (i == 7) begin
        chk("b2b_pulse1", 512'(out_avl), 512'(1));
        chk("b2b_slot0", 512'(out_data[0]), 512'({32'd0, 32'd100}));
        chk("b2b_slot3", 512'(out_data[3]), 512'({32'd3, 32'd103}));
        chk("b2b_slot7", 512'(out_data[7]), 512'({32'd7, 32'd107}));
        chk("b2b_count", 512'(out_count), 512'(8));
        chk("b2b_last", 512'(out_last), 512'(0));
      end else if (i == 15) begin
        chk("b2b_pulse2", 512'(out_avl), 512'(1));
        chk("b2b2_slot0", 512'(out_data[0]), 512'({32'd8, 32'd108}));
      end else begin
        chk("b2b_quiet", 512'(out_avl), 512'(0));
      end
    end

    // Short batch closed by in_last on the 3rd element.
    drive(1'b1, 1'b0, 1'b0, {32'd5, 32'd5});
    drive(1'b1, 1'b0, 1'b0, {32'd6, 32'd6});
    drive(1'b1, 1'b1, 1'b0, {32'd7, 32'd7});
    eb = '0; eb[0] = {32'd5, 32'd5}; eb[1] = {32'd6, 32'd6}; eb[2] = {32'd7, 32'd7};
    chk("last_avl", 512'(out_avl), 512'(1));
    chk("last_data", 512'(out_data), 512'(eb));
    chk("last_count", 512'(out_count), 512'(3));
    chk("last_flag", 512'(out_last), 512'(1));

    // Two elements, idle gap, flush; then flush on an empty buffer.
    drive(1'b1, 1'b0, 1'b0, {32'd11, 32'd12});
    drive(1'b1, 1'b0, 1'b0, {32'd13, 32'd14});
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("gap_quiet", 512'(out_avl), 512'(0));
    drive(1'b0, 1'b0, 1'b1, '0);
    eb = '0; eb[0] = {32'd11, 32'd12}; eb[1] = {32'd13, 32'd14};
    chk("flush_avl", 512'(out_avl), 512'(1));
    chk("flush_data", 512'(out_data), 512'(eb));
    chk("flush_count", 512'(out_count), 512'(2));
    chk("flush_last", 512'(out_last), 512'(1));
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("flush_empty", 512'(out_avl), 512'(0));

    // Flush together with the 4th element.
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 1'b0, {32'(i), 32'(i)});
    drive(1'b1, 1'b0, 1'b1, {32'hAAAA, 32'h5555});
    chk("fl4_count", 512'(out_count), 512'(4));
    chk("fl4_slot3", 512'(out_data[3]), 512'({32'hAAAA, 32'h5555}));
    chk("fl4_last", 512'(out_last), 512'(1));

    // Reset mid-batch discards the partial contents.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, {32'hDEAD, 32'(i)});
    do_reset();
    p0 = pulses;
    eb = '0;
    for (int i = 0; i < 8; i++) begin
      eb[i] = {32'hBEEF, 32'(i)};
      drive(1'b1, 1'b0, 1'b0, eb[i]);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("rst_pulses", 512'(pulses - p0), 512'(1));
    chk("rst_data", 512'(out_data), 512'(eb));

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10, {$urandom, $urandom});
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
